// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0]     ZeroWord    = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] IF_RESET_PC = 32'h0000_0000;

    // FETCH: request outstanding at fetch_pc.
    // HOLD: one instruction parked in the skid buffer, no request.
    // DISCARD: abandoned request outstanding, its data will be dropped.
    typedef enum logic [1:0] {
        IF_ST_FETCH   = 2'd0,
        IF_ST_HOLD    = 2'd1,
        IF_ST_DISCARD = 2'd2
    } if_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry pc+inst buffer used when a fetched word cannot be delivered.
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [InstAddrBus-1:0] i_pc,
    input  logic [InstBus-1:0]     i_inst,
    output logic                   o_valid,
    output logic [InstAddrBus-1:0] o_pc,
    output logic [InstBus-1:0]     o_inst
);

    logic                   r_valid;
    logic [InstAddrBus-1:0] r_pc;
    logic [InstBus-1:0]     r_inst;

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= ZeroWord;
            r_inst  <= ZeroWord;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches over a
// req/ready handshake and delivers (pc, inst) pairs to IF/ID, honouring
// branch/jump redirects from EX.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   b_flag_i,
    input  logic [InstAddrBus-1:0] b_target_addr_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_ready_i,
    input  logic [InstBus-1:0]     mem_rdata_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o
);

    if_state_e              r_state;
    logic [InstAddrBus-1:0] r_fetch_pc;
    logic [InstAddrBus-1:0] r_disc_addr;
    logic [InstAddrBus-1:0] r_pc;
    logic [InstBus-1:0]     r_inst;
    logic                   r_valid;

    if_state_e              w_next_state;
    logic [InstAddrBus-1:0] w_next_fetch_pc;
    logic [InstAddrBus-1:0] w_pc_plus4;
    logic                   w_req_active;
    logic                   w_slot_free;
    logic                   w_disc_load;
    logic                   w_out_load;
    logic                   w_out_bubble;
    logic [InstAddrBus-1:0] w_out_pc;
    logic [InstBus-1:0]     w_out_inst;
    logic                   w_buf_load;
    logic                   w_buf_clear;
    logic                   w_buf_valid;
    logic [InstAddrBus-1:0] w_buf_pc;
    logic [InstBus-1:0]     w_buf_inst;

    // A request is in flight in FETCH and DISCARD; HOLD waits for the consumer.
    assign w_req_active = (r_state == IF_ST_FETCH) || (r_state == IF_ST_DISCARD);
    assign w_slot_free  = ~r_valid | ~stall_i;
    assign w_pc_plus4   = r_fetch_pc + 32'd4;

    assign mem_req_o    = w_req_active & ~rst;
    assign mem_addr_o   = (r_state == IF_ST_DISCARD) ? r_disc_addr : r_fetch_pc;

    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

    if_skid_buf u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_pc    (r_fetch_pc),
        .i_inst  (mem_rdata_i),
        .o_valid (w_buf_valid),
        .o_pc    (w_buf_pc),
        .o_inst  (w_buf_inst)
    );

    // Next-state, fetch PC and output-slot control; redirect overrides everything.
    always_comb begin
        w_next_state    = r_state;
        w_next_fetch_pc = r_fetch_pc;
        w_disc_load     = 1'b0;
        w_out_load      = 1'b0;
        w_out_bubble    = 1'b0;
        w_out_pc        = r_pc;
        w_out_inst      = r_inst;
        w_buf_load      = 1'b0;
        w_buf_clear     = 1'b0;

        if (b_flag_i) begin
            w_out_bubble    = 1'b1;
            w_buf_clear     = 1'b1;
            w_next_fetch_pc = word_align(b_target_addr_i);
            if (w_req_active && !mem_ready_i) begin
                // Memory still owes us a word for the old stream; wait it out.
                w_next_state = IF_ST_DISCARD;
                if (r_state == IF_ST_FETCH) begin
                    w_disc_load = 1'b1;
                end
            end else begin
                w_next_state = IF_ST_FETCH;
            end
        end else begin
            case (r_state)
                IF_ST_FETCH: begin
                    if (mem_ready_i) begin
                        w_next_fetch_pc = w_pc_plus4;
                        if (w_slot_free) begin
                            w_out_load = 1'b1;
                            w_out_pc   = r_fetch_pc;
                            w_out_inst = mem_rdata_i;
                        end else begin
                            w_buf_load   = 1'b1;
                            w_next_state = IF_ST_HOLD;
                        end
                    end else if (w_slot_free) begin
                        w_out_bubble = 1'b1;
                    end
                end
                IF_ST_HOLD: begin
                    if (!stall_i) begin
                        w_out_load   = 1'b1;
                        w_out_pc     = w_buf_pc;
                        w_out_inst   = w_buf_inst;
                        w_buf_clear  = 1'b1;
                        w_next_state = IF_ST_FETCH;
                    end
                end
                IF_ST_DISCARD: begin
                    w_out_bubble = 1'b1;
                    if (mem_ready_i) begin
                        w_next_state = IF_ST_FETCH;
                    end
                end
                default: begin
                    w_next_state = IF_ST_FETCH;
                end
            endcase
        end
    end

    // State, fetch PC and abandoned-request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IF_ST_FETCH;
            r_fetch_pc  <= RESET_PC;
            r_disc_addr <= ZeroWord;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_fetch_pc;
            if (w_disc_load) begin
                r_disc_addr <= r_fetch_pc;
            end
        end
    end

    // IF/ID-facing output registers; a bubble only clears the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= ZeroWord;
            r_inst  <= ZeroWord;
            r_valid <= 1'b0;
        end else if (w_out_bubble) begin
            r_valid <= 1'b0;
        end else if (w_out_load) begin
            r_pc    <= w_out_pc;
            r_inst  <= w_out_inst;
            r_valid <= 1'b1;
        end
    end

    // The buffer valid flag mirrors HOLD; it is kept for readability of the buffer state.
    logic w_unused;
    assign w_unused = w_buf_valid;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the RISC-V pipeline. Owns the fetch PC and issues word fetches to instruction memory over a req/ready handshake. Delivers (pc, inst) pairs to the IF/ID register. It consumes the branch/jump redirect (`b_flag`, `b_target_addr`) produced by the EX stage, flushing fetched-but-undelivered work and restarting at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `stall_i` in 1: the downstream stage cannot accept a new instruction this cycle.
- `b_flag_i` in 1: redirect pulse from EX, one cycle per taken branch/jump.
- `b_target_addr_i` in 32 (`InstAddrBus`): redirect target. Bits [1:0] are forced to 0 internally.
- `mem_req_o` out 1: fetch request.
- `mem_addr_o` out 32: fetch address. Word aligned and stable while `mem_req_o` is high and no `mem_ready_i` has been received.
- `mem_ready_i` in 1: response strobe. It is sampled only while `mem_req_o` is high, and data is valid in the same cycle.
- `mem_rdata_i` in 32: instruction word.
- `pc_o` out 32: registered PC of the delivered instruction.
- `inst_o` out 32: registered instruction word.
- `inst_valid_o` out 1: registered. `pc_o`/`inst_o` hold a live instruction.

## Operation
- The FSM has three states:
  - FETCH: request outstanding at `fetch_pc`.
  - HOLD: one instruction is parked in the skid buffer.
  - DISCARD: a request is outstanding whose data must be dropped.
- Output slot is free ⇔ `~inst_valid_o | ~stall_i`.
- FETCH:
  - `mem_req_o` = 1 and `mem_addr_o` = `fetch_pc`.
  - On `mem_ready_i` with the slot free: load the outputs with {`fetch_pc`, `mem_rdata_i`, 1}, set `fetch_pc` += 4, stay in FETCH.
  - On `mem_ready_i` with the slot not free: buffer {`fetch_pc`, `mem_rdata_i`}, set `fetch_pc` += 4, go to HOLD.
  - With no `mem_ready_i` and the slot free: `inst_valid_o` ← 0 (the consumed instruction becomes a bubble).
- HOLD:
  - `mem_req_o` = 0. Outputs are held while `stall_i` = 1.
  - When `stall_i` = 0: outputs ← buffer with `inst_valid_o` ← 1, go to FETCH.
- DISCARD:
  - `mem_req_o` = 1 and `mem_addr_o` = `disc_addr` (the address of the abandoned request, held stable). `inst_valid_o` = 0.
  - On `mem_ready_i`: data is dropped, go to FETCH. `fetch_pc` already holds the target.
- Redirect (`b_flag_i` = 1) has the highest priority in every state and is honoured even when `stall_i` = 1:
  - `inst_valid_o` ← 0, the buffer is cleared, `fetch_pc` ← {`b_target_addr_i`[31:2], 2'b00}.
  - Next state is DISCARD if a request is outstanding this cycle and `mem_ready_i` = 0, otherwise FETCH.
  - Entering DISCARD from FETCH latches `disc_addr` ← current `mem_addr_o`.
  - A redirect while already in DISCARD only updates `fetch_pc`.
  - A redirect coinciding with `mem_ready_i` drops that data; the target is fetched next cycle.
- `fetch_pc` wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (async, immediate):
  - State = FETCH, `fetch_pc` = `RESET_PC`, buffer empty.
  - `pc_o` = 0, `inst_o` = 0, `inst_valid_o` = 0.
  - `mem_req_o` is gated to 0 while `rst` is high. The first request goes to `RESET_PC` in the first cycle after deassertion.
- Reset mid-request abandons it. Instruction memory must tolerate `mem_req_o` dropping without `mem_ready_i`.
- Latency: an instruction is visible on `inst_valid_o` the cycle after its `mem_ready_i`. With zero-wait memory (ready in the same cycle as req), throughput is 1 instruction/cycle.
- First instruction after a redirect: if `mem_ready_i` returns in the same cycle as the target request, it appears 2 cycles after `b_flag_i`. Each cycle spent in DISCARD adds one cycle.
- No instruction fetched before a redirect may appear on the outputs after the redirect cycle.

## Structure
- Add to `Defines.vh`:
  - state encodings `IF_ST_FETCH`, `IF_ST_HOLD`, `IF_ST_DISCARD`;
  - `RESET_PC` default constant.
- Reuse `InstAddrBus`, `InstBus`, and `ZeroWord` from the same file.
- One natural sub-module: `if_skid_buf`, the one-entry pc+inst buffer with load/clear/valid. Everything else stays inline.

## Test plan
- **Reset:** assert `rst` mid-cycle, then release.
  - Outputs drop to 0 asynchronously.
  - One cycle after release, `mem_req_o` = 1 with `mem_addr_o` = `RESET_PC`.
- **Streaming:** zero-wait memory returning `addr ^ 32'hA5A5_0000`.
  - `pc_o` sequence 0, 4, 8, 12 on consecutive cycles.
  - `inst_o` matches the returned words.
  - `inst_valid_o` stays 1.
- **Stall:** `stall_i` = 1 for 3 cycles while showing pc = 8.
  - pc = 8 is held throughout.
  - pc = 12 is buffered and `mem_req_o` = 0 in HOLD.
  - After release, pc = 12 follows with no duplicate and no loss.
- **Redirect during wait:** `mem_ready_i` delayed 3 cycles at addr 0x10; `b_flag_i` with target 0x103 while waiting.
  - `mem_addr_o` stays 0x10 until ready, and that data is dropped.
  - Next request is 0x100; no instruction is delivered from 0x10.
- **Redirect with ready and stall:** `b_flag_i` coinciding with `mem_ready_i` and `stall_i` = 1 (target 0x40).
  - `inst_valid_o` = 0 next cycle and the buffer is empty.
  - Next `mem_addr_o` = 0x40.
- **Wrap:** `b_flag_i` target 0xFFFF_FFFC.
  - Delivered `pc_o` sequence is 0xFFFF_FFFC, then 0x0000_0000.
